div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider in the EXU, in parallel with the single-cycle ALU.
- Takes decoded operands and a divide opcode from the ID/EX register and returns a 64-bit result toward WBU over a valid/ready handshake.
- Covers RV64M DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW, including the ISA-defined divide-by-zero and overflow results.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- CNT_W, 7, width of the iteration counter; must hold XLEN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and control valid
- in_ready  out  1  divider can accept an operation
- src1  in  64  dividend
- src2  in  64  divisor
- control  in  4  [0]=0 quotient / 1 remainder; [1]=1 unsigned; [2]=1 word (32-bit) op; [3] reserved, ignored
- flush  in  1  abort the current operation (pipeline redirect)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result_out  out  64  quotient or remainder, per control

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result_out=0, counter=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch control, take operand magnitudes, set sign flags. Next state is DONE for a special case, otherwise CALC.
  - CALC: one quotient bit per cycle, MSB first. Shift {rem,quo} left 1. Trial-subtract the divisor. If the result is non-negative, keep it and set quo[0]=1. Run N=64 iterations, or N=32 for word ops. Go to FIX when counter==N-1.
  - FIX: negate the quotient if the operand signs differ (signed ops only). Give the remainder the dividend's sign. Select quotient or remainder. For word ops, sign-extend bit 31 of the 32-bit result to 64; this applies to DIVUW/REMUW too. Go to DONE.
  - DONE: out_valid=1, result_out held stable. On out_ready, go to IDLE.
- Word ops: operands are the low 32 bits, sign-extended if signed, zero-extended if unsigned.
- Latency from the accept edge:
  - normal op: N+2 cycles to out_valid (N CALC cycles + 1 FIX cycle + registered DONE);
  - special case: 1 cycle.
- Special cases, decided in IDLE; the CALC state is skipped:
  - divisor==0: quotient = all ones; remainder = dividend (word-extended for word ops).
  - signed overflow (dividend = most negative value, divisor = -1, at the op width): quotient = dividend; remainder = 0.
- in_ready=0 in every state except IDLE. Back-to-back accept in DONE is not supported.
- Handshake: result_out must not change while out_valid=1 and out_ready=0. Inputs are ignored when in_ready=0.
- flush: from any state, next state is IDLE and out_valid drops the next cycle. flush in IDLE together with in_valid means the operation is not accepted.
- rst mid-operation: returns to the reset values at the next edge; no partial result is emitted.
- control[3] does not affect the result.

Decomposition:
- Shared package: control bit positions (CTRL_REM=0, CTRL_UNS=1, CTRL_WORD=2), state encoding (IDLE, CALC, FIX, DONE), XLEN.
- One natural sub-module: div_special_chk. It is combinational: it flags divide-by-zero and overflow and produces the corresponding result from src1, src2 and control.

Test Plan:
- DIV: src1=100, src2=7, control=0 -> out_valid on the 66th cycle after the accept edge, result_out=14; repeat with control=1 (REM) -> 2.
- Signed: src1=-100, src2=7, DIV -> 0xFFFFFFFFFFFFFFF2 (-14); REM -> 0xFFFFFFFFFFFFFFFE (-2).
- Divide by zero: DIVU src1=5, src2=0 -> 0xFFFFFFFFFFFFFFFF one cycle after accept; REMU -> 5.
- Overflow: DIV src1=0x8000000000000000, src2=-1 -> 0x8000000000000000; DIVW src1=0x80000000, src2=0xFFFFFFFF -> 0xFFFFFFFF80000000; REMW with the same operands -> 0.
- Word extension: DIVUW src1=0xFFFFFFFE, src2=1 -> 0xFFFFFFFFFFFFFFFE, out_valid 34 cycles after accept.
- Handshake/abort:
  - hold out_ready=0 for 5 cycles: result stable, in_ready=0 throughout;
  - flush at CALC cycle 10: IDLE next cycle, no out_valid;
  - rst in FIX: all outputs return to their reset values at the next edge.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider.
//   XLEN / CNT_W        : datapath and iteration-counter widths
//   CTRL_*              : bit positions inside the 4-bit control field
//   state_t             : divider FSM encoding
//   ext_op()            : word-op operand extension (sign or zero)
//   sext_w()            : sign-extend bit 31 of a word result to XLEN
package div_iter_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  localparam int CTRL_REM  = 0;  // 0 = quotient, 1 = remainder
  localparam int CTRL_UNS  = 1;  // 1 = unsigned
  localparam int CTRL_WORD = 2;  // 1 = 32-bit word op

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Word ops divide the low 32 bits, widened according to signedness.
  function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] x,
                                             input logic word,
                                             input logic uns);
    if (!word)
      return x;
    else if (uns)
      return {{(XLEN-32){1'b0}}, x[31:0]};
    else
      return {{(XLEN-32){x[31]}}, x[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
    return {{(XLEN-32){x[31]}}, x[31:0]};
  endfunction

endpackage

// File: rtl/div_special_chk.sv
// Combinational detector for the divide cases that bypass the iteration.
//   src1, src2      : raw dividend / divisor
//   control         : op control ([0] rem, [1] unsigned, [2] word, [3] ignored)
//   is_special      : divide-by-zero or signed overflow at the op width
//   special_result  : architectural result for that case (word ops sign-extended)
module div_special_chk import div_iter_pkg::*; (
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [3:0]      control,
  output logic            is_special,
  output logic [XLEN-1:0] special_result
);

  logic            word;
  logic            uns;
  logic            rem;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] min_val;
  logic [XLEN-1:0] raw;
  logic            div_zero;
  logic            ovf;
  logic            unused_ctrl;

  assign unused_ctrl = control[3];

  always_comb begin
    word = control[CTRL_WORD];
    uns  = control[CTRL_UNS];
    rem  = control[CTRL_REM];
    a    = ext_op(src1, word, uns);
    b    = ext_op(src2, word, uns);
    // Most negative value at the op width, already in its extended form.
    min_val = word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};

    div_zero = (b == '0);
    ovf      = !uns && (a == min_val) && (b == '1);
    is_special = div_zero || ovf;

    raw = '0;
    if (div_zero)
      raw = rem ? a : '1;
    else if (ovf)
      raw = rem ? '0 : a;

    // Word results are always sign-extended from bit 31, unsigned included.
    special_result = word ? sext_w(raw) : raw;
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider (RV64M DIV/DIVU/REM/REMU + word forms).
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operation handshake (accepted only in IDLE)
//   src1, src2, control   : dividend, divisor, op control
//   flush                 : abort; FSM returns to IDLE next cycle
//   out_valid / out_ready : result handshake
//   result_out            : quotient or remainder, held while out_valid && !out_ready
// Handshake: a transfer happens on a clock edge where valid and ready are
// both high; once out_valid rises, result_out stays constant until that
// transfer completes, and inputs are ignored while in_ready is low.
module div_iter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [3:0]      control,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_out
);
  import div_iter_pkg::*;

  state_t          state;
  state_t          next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] dvs_r;
  logic            op_rem;
  logic            op_word;
  logic            neg_q;
  logic            neg_r;

  logic            spec_hit;
  logic [XLEN-1:0] spec_res;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            a_neg;
  logic            b_neg;
  logic            accept;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] fix_q;
  logic [XLEN-1:0] fix_r;
  logic [XLEN-1:0] fix_res;

  div_special_chk u_special (
    .src1           (src1),
    .src2           (src2),
    .control        (control),
    .is_special     (spec_hit),
    .special_result (spec_res)
  );

  // Operand magnitudes and signs, computed from the live inputs in IDLE.
  always_comb begin
    a_ext = ext_op(src1, control[CTRL_WORD], control[CTRL_UNS]);
    b_ext = ext_op(src2, control[CTRL_WORD], control[CTRL_UNS]);
    a_neg = !control[CTRL_UNS] && a_ext[XLEN-1];
    b_neg = !control[CTRL_UNS] && b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end

  assign accept   = (state == IDLE) && in_valid && !flush;
  assign last_cnt = op_word ? CNT_W'(31) : CNT_W'(63);

  // Trial subtraction on the shifted partial remainder; the borrow bit
  // (trial[XLEN]) set means the divisor did not fit.
  assign trial = {rem_r, quo_r[XLEN-1]} - {1'b0, dvs_r};

  always_comb begin
    fix_q   = neg_q ? -quo_r : quo_r;
    fix_r   = neg_r ? -rem_r : rem_r;
    fix_res = op_rem ? fix_r : fix_q;
    if (op_word)
      fix_res = sext_w(fix_res);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // FSM: next state
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = spec_hit ? DONE : CALC;
      CALC:    if (cnt == last_cnt) next_state = FIX;
      FIX:     next_state = DONE;
      DONE:    if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush)
      next_state = IDLE;
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state == IDLE);
  end

  // Datapath and registered result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      dvs_r      <= '0;
      op_rem     <= 1'b0;
      op_word    <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      result_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_rem  <= control[CTRL_REM];
            op_word <= control[CTRL_WORD];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            cnt     <= '0;
            rem_r   <= '0;
            // Word dividends sit in the upper half so the MSB-first shift
            // consumes exactly 32 bits and leaves the quotient in [31:0].
            quo_r   <= control[CTRL_WORD] ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
            dvs_r   <= b_mag;
            if (spec_hit)
              result_out <= spec_res;
          end
        end
        CALC: begin
          cnt   <= cnt + 1'b1;
          rem_r <= trial[XLEN] ? {rem_r[XLEN-2:0], quo_r[XLEN-1]} : trial[XLEN-1:0];
          quo_r <= {quo_r[XLEN-2:0], ~trial[XLEN]};
        end
        FIX:     result_out <= fix_res;
        default: ;
      endcase

      // out_valid rises one cycle after DONE is entered and drops with the
      // accepting transfer or an abort.
      if (flush)
        out_valid <= 1'b0;
      else if (state == DONE)
        out_valid <= !(out_valid && out_ready);
      else
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [3:0]   control;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result_out;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  div_iter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src1       (src1),
    .src2       (src2),
    .control    (control),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] c);
    logic        rem, uns, word;
    logic [31:0] a32, b32, r32;
    logic [W-1:0] r;
    rem = c[0]; uns = c[1]; word = c[2];
    if (word) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0)
        r32 = rem ? a32 : 32'hFFFF_FFFF;
      else if (!uns && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
        r32 = rem ? 32'd0 : a32;
      else if (uns)
        r32 = rem ? (a32 % b32) : (a32 / b32);
      else
        r32 = rem ? ($signed(a32) % $signed(b32)) : ($signed(a32) / $signed(b32));
      return {{32{r32[31]}}, r32};
    end
    if (b == '0)
      r = rem ? a : '1;
    else if (!uns && a == 64'h8000_0000_0000_0000 && b == '1)
      r = rem ? '0 : a;
    else if (uns)
      r = rem ? (a % b) : (a / b);
    else
      r = rem ? ($signed(a) % $signed(b)) : ($signed(a) / $signed(b));
    return r;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    logic sp;
    if (c[2])
      sp = (b[31:0] == 32'd0) || (!c[1] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else
      sp = (b == '0) || (!c[1] && a == 64'h8000_0000_0000_0000 && b == '1);
    if (sp) return 1;
    return c[2] ? 34 : 66;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 20));
      2:       return -64'($urandom_range(1, 20));
      3:       return 64'h8000_0000_0000_0000;
      4:       return {32'h0, $urandom};
      5:       return 64'h0000_0000_8000_0000;
      default: return {{32{1'b1}}, $urandom};
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                        input int hold, input logic use_want, input logic [W-1:0] want);
    int           lat;
    logic         busy_ok;
    logic [W-1:0] exp_v;
    check("idle_in_ready", 64'(in_ready), 64'(1));
    src1 = a; src2 = b; control = c; in_valid = 1'b1;
    exp_q.push_back(use_want ? want : ref_div(a, b, c));
    tick();
    in_valid = 1'b0;
    // inputs must be ignored once accepted
    src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom}; control = 4'($urandom_range(0, 15));
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
    check("busy_in_ready_low", 64'(busy_ok), 64'(1));
    check("latency", 64'(lat), 64'(exp_lat(a, b, c)));
    exp_v = exp_q.pop_front();
    check("result", result_out, exp_v);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_result", result_out, exp_v);
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", 64'(out_valid), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic seen;
    logic [3:0] c;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; control = '0;
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", result_out, 64'(0));
    rst = 1'b0;
    tick();

    // directed cases with hand-derived results
    run_op(64'd100, 64'd7, 4'b0000, 0, 1'b1, 64'd14);
    run_op(64'd100, 64'd7, 4'b0001, 0, 1'b1, 64'd2);
    run_op(-64'd100, 64'd7, 4'b0000, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op(-64'd100, 64'd7, 4'b0001, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(64'd5, 64'd0, 4'b0010, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op(64'd5, 64'd0, 4'b0011, 0, 1'b1, 64'd5);
    run_op(64'h8000_0000_0000_0000, '1, 4'b0000, 0, 1'b1, 64'h8000_0000_0000_0000);
    run_op(64'h8000_0000, 64'hFFFF_FFFF, 4'b0100, 0, 1'b1, 64'hFFFF_FFFF_8000_0000);
    run_op(64'h8000_0000, 64'hFFFF_FFFF, 4'b0101, 0, 1'b1, 64'd0);
    run_op(64'hFFFF_FFFE, 64'd1, 4'b0110, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(64'd100, 64'd7, 4'b1000, 0, 1'b1, 64'd14);
    run_op(64'd100, 64'd7, 4'b0000, 5, 1'b1, 64'd14);
    run_op(64'hFFFF_FFFF, 64'd0, 4'b0111, 2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

    // flush during CALC
    src1 = 64'd100; src2 = 64'd7; control = 4'b0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle", 64'(in_ready), 64'(1));
    seen = 1'b0;
    repeat (80) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", 64'(seen), 64'(0));

    // flush together with in_valid in IDLE: not accepted
    src1 = 64'd9; src2 = 64'd0; control = 4'b0000; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_reject", 64'(in_ready), 64'(1));
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("flush_reject_no_valid", 64'(seen), 64'(0));

    // reset while in FIX, with a nonzero result still registered
    run_op(64'd100, 64'd7, 4'b0000, 0, 1'b1, 64'd14);
    src1 = 64'd1000; src2 = 64'd3; control = 4'b0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (64) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstfix_in_ready", 64'(in_ready), 64'(1));
    check("rstfix_out_valid", 64'(out_valid), 64'(0));
    check("rstfix_result", result_out, 64'(0));
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("rstfix_no_partial", 64'(seen), 64'(0));

    // randomized operations against the reference model
    for (int n = 0; n < 50; n++) begin
      c = 4'($urandom_range(0, 15));
      run_op(rnd_val(), rnd_val(), c, $urandom_range(0, 2), 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
